// File: rtl/alu_sched.sv
// alu_sched: two-port round-robin scheduler that holds operands stable on a shared
// combinational ALU for an op-dependent number of cycles, then returns the result.
module alu_sched #(
   parameter int W        = 16,
   parameter int LAT_CPLX = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [3:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [3:0]   req1_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_control,
   input  logic [W-1:0] alu_result,
   input  logic [W-1:0] alu_result_x,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_result,
   output logic [W-1:0] rsp_result_x,
   output logic         rsp_err,
   output logic         busy
);
   localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
   logic [1:0]   state;
   logic         last;
   logic [3:0]   cnt;
   logic         id_q, err_q;
   logic         g0, g1, accept, cplx, err_in;
   logic [W-1:0] a_in, b_in;
   logic [3:0]   op_in;
   // On a tie the requester not granted last time wins.
   assign g0         = req0_valid & (~req1_valid | last);
   assign g1         = req1_valid & (~req0_valid | ~last);
   assign req0_ready = rst_n & (state == IDLE) & g0;
   assign req1_ready = rst_n & (state == IDLE) & g1;
   assign accept     = req0_ready | req1_ready;
   assign a_in       = g1 ? req1_a : req0_a;
   assign b_in       = g1 ? req1_b : req0_b;
   assign op_in      = g1 ? req1_op : req0_op;
   assign cplx       = op_in[3:2] == 2'b10;
   assign err_in     = (op_in[3:2] == 2'b11) | ((op_in == 4'h9) & (b_in == '0));
   assign busy       = state != IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         last         <= 1'b1;
         cnt          <= '0;
         id_q         <= 1'b0;
         err_q        <= 1'b0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_control  <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_result_x <= '0;
         rsp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               alu_a       <= a_in;
               alu_b       <= b_in;
               alu_control <= op_in;
               id_q        <= g1;
               last        <= g1;
               err_q       <= err_in;
               cnt         <= cplx ? 4'(LAT_CPLX) : 4'd1;
               state       <= EXEC;
            end
            EXEC: begin
               cnt <= cnt - 4'd1;
               // ALU inputs have been stable for the full path delay by now.
               if (cnt == 4'd1) begin
                  rsp_result   <= alu_result;
                  rsp_result_x <= alu_result_x;
                  rsp_id       <= id_q;
                  rsp_err      <= err_q;
                  rsp_valid    <= 1'b1;
                  state        <= RESP;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized bench for alu_sched with a transaction-level reference
// model and a behavioural stand-in ALU driving alu_result/alu_result_x.
module tb_alu_sched;
   localparam int W = 16;
   localparam int L = 4;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   op;
   } cmd_t;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]   req0_op, req1_op;
   logic [W-1:0] alu_a, alu_b, alu_result, alu_result_x;
   logic [3:0]   alu_control;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [W-1:0] rsp_result, rsp_result_x;
   logic [31:0]  alu_out;
   int           errors = 0;
   int           checks = 0;
   cmd_t         q0[$], q1[$];
   bit           m_busy, m_resp, m_last, acc0, acc1, rst_done, post_pushed;
   int           m_wait;
   logic [W-1:0] m_a, m_b, p_res, p_x, e_res, e_x;
   logic [3:0]   m_op;
   logic         p_id, p_err, e_id, e_err;

   always #5 clk = ~clk;

   alu_sched #(.W(W), .LAT_CPLX(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_result_x(alu_result_x),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_result_x(rsp_result_x), .rsp_err(rsp_err), .busy(busy)
   );

   // Stand-in ALU: {result_x, result}
   function automatic logic [31:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      logic [W-1:0] r;
      r = '0;
      case (op)
         4'h1: return {16'd0, a - b};
         4'h2: return {16'd0, a & b};
         4'h3: return {16'd0, a | b};
         4'h4: return {16'd0, a ^ b};
         4'h5: return {16'd0, ~a};
         4'h6: return {16'd0, a << b[3:0]};
         4'h7: return {16'd0, a >> b[3:0]};
         4'h8: return 32'(a) * 32'(b);
         4'h9: return (b == 0) ? 32'd0 : {a % b, a / b};
         4'hA: begin
            for (int i = 0; i < W; i++) if (a[i]) r = W'(i);
            return {16'd0, r};
         end
         4'hB: begin
            for (int i = 0; i < 256; i++) if (i * i <= int'(a)) r = W'(i);
            return {16'd0, r};
         end
         default: return {15'd0, 17'(a) + 17'(b)};
      endcase
   endfunction

   assign alu_out      = alu_f(alu_a, alu_b, alu_control);
   assign alu_result   = alu_out[W-1:0];
   assign alu_result_x = alu_out[2*W-1:W];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_resp = 0; m_last = 1; m_wait = 0;
      m_a = '0; m_b = '0; m_op = '0;
      e_id = 0; e_err = 0; e_res = '0; e_x = '0;
   endtask

   // Checks current outputs, then advances the model across the coming edge.
   task automatic step();
      int w;
      logic [31:0] r;
      w = -1;
      if (rst_n && !m_busy) begin
         if (req0_valid && !req1_valid) w = 0;
         else if (req1_valid && !req0_valid) w = 1;
         else if (req0_valid && req1_valid) w = m_last ? 0 : 1;
      end
      check("ready0", 32'(req0_ready), 32'(w == 0));
      check("ready1", 32'(req1_ready), 32'(w == 1));
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      check("rsp_id", 32'(rsp_id), 32'(e_id));
      check("rsp_result", 32'(rsp_result), 32'(e_res));
      check("rsp_result_x", 32'(rsp_result_x), 32'(e_x));
      check("rsp_err", 32'(rsp_err), 32'(e_err));
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_control", 32'(alu_control), 32'(m_op));
      acc0 = 0; acc1 = 0;
      if (!rst_n) model_reset();
      else if (w >= 0) begin
         acc0 = (w == 0); acc1 = (w == 1);
         m_last = (w == 1);
         m_a  = acc1 ? req1_a : req0_a;
         m_b  = acc1 ? req1_b : req0_b;
         m_op = acc1 ? req1_op : req0_op;
         m_wait = (m_op >= 4'h8 && m_op <= 4'hB) ? L : 1;
         r = alu_f(m_a, m_b, m_op);
         p_res = r[W-1:0]; p_x = r[2*W-1:W]; p_id = acc1;
         p_err = (m_op >= 4'hC) || (m_op == 4'h9 && m_b == 0);
         m_busy = 1;
      end else if (m_busy && !m_resp) begin
         m_wait--;
         if (m_wait == 0) begin
            m_resp = 1; e_id = p_id; e_res = p_res; e_x = p_x; e_err = p_err;
         end
      end else if (m_resp && rsp_ready) begin
         m_resp = 0; m_busy = 0;
      end
   endtask

   function automatic cmd_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      cmd_t c;
      c.a = a; c.b = b; c.op = op;
      return c;
   endfunction

   function automatic cmd_t rnd();
      return mk(W'($urandom), ($urandom_range(0, 3) == 0) ? '0 : W'($urandom), 4'($urandom));
   endfunction

   task automatic drive(input int c);
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      rst_n = 1;
      rsp_ready = 1;
      if (c == 1) q0.push_back(mk(16'h0003, 16'h0005, 4'h0));
      if (c == 10) q1.push_back(mk(16'h0100, 16'h0100, 4'h8));
      if (c == 20) begin
         q0.push_back(mk(16'h0010, 16'h0000, 4'h9));
         q1.push_back(mk(16'h0002, 16'h0003, 4'hD));
      end
      if (c == 32) repeat (2) begin
         q0.push_back(mk(16'h0009, 16'h0004, 4'h1));
         q1.push_back(mk(16'h0007, 16'h0002, 4'h1));
      end
      if (c == 48) begin
         q0.push_back(mk(16'h1234, 16'h00ff, 4'h2));
         q1.push_back(mk(16'h4321, 16'h0f0f, 4'h4));
      end
      if (c >= 50 && c < 62) rsp_ready = 0;
      if (c == 80) q0.push_back(mk(16'h0090, 16'h0000, 4'hB));
      if (c > 80 && !rst_done && m_busy && !m_resp && m_wait > 1) begin
         rst_n = 0; rst_done = 1;
      end else if (rst_done && !post_pushed) begin
         q1.push_back(mk(16'h0020, 16'h0001, 4'h6));
         post_pushed = 1;
      end
      if (c >= 150) begin
         if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rnd());
         if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rnd());
         rsp_ready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 199) == 0) rst_n = 0;
      end
      req0_valid = q0.size() != 0;
      if (req0_valid) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op; end
      req1_valid = q1.size() != 0;
      if (req1_valid) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op; end
   endtask

   initial begin
      rst_n = 0; rsp_ready = 0;
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
      rst_done = 0; post_pushed = 0; acc0 = 0; acc1 = 0;
      repeat (2) @(negedge clk);
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         step();
         @(posedge clk);
         #1;
         drive(c);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port round-robin scheduler that shares one combinational `alu` instance (ops 0x0–0xB, including the multi-cycle-path `multi`, `divide`, `log_e` and `sqrt` paths) between two requesters. It accepts one command at a time over a valid/ready handshake and registers the operands onto the ALU inputs. It holds those inputs stable for an op-dependent number of cycles, then captures `result`/`result_X` into a response register with valid/ready backpressure. It sits between the two command sources and the `alu` datapath.

## Interface
- `W`, 16, operand and result width; must match the ALU.
- `LAT_CPLX`, 4, EXEC cycles for ops 0x8–0xB; legal range 1–15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req0_valid` input 1: requester 0 has a command.
- `req0_ready` output 1: requester 0's command is accepted this cycle.
- `req0_a`, `req0_b` input W: requester 0 operands.
- `req0_op` input 4: requester 0 ALU control code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `alu_a`, `alu_b` output W: registered operands to the ALU `A`/`B`.
- `alu_control` output 4: registered op to the ALU `control`.
- `alu_result`, `alu_result_x` input W: from the ALU `result`/`result_X`.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer takes the response.
- `rsp_id` output 1: index of the requester that issued the command.
- `rsp_result`, `rsp_result_x` output W: captured ALU outputs.
- `rsp_err` output 1: command flagged as erroneous.
- `busy` output 1: state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Encoding is free.
- **IDLE, arbitration**
  - `reqN_ready` is combinational and asserts only in IDLE, for the granted requester.
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester not granted last time wins. The `last` pointer resets to 1, so requester 0 wins the first tie.
  - The non-granted `ready` stays 0.
- **IDLE, accept** (on valid&ready):
  - Load `alu_a`/`alu_b`/`alu_control` from the granted port.
  - Latch the id and update `last`.
  - Load `cnt` = 1 for ops 0x0–0x7 and 0xC–0xF, or `LAT_CPLX` for ops 0x8–0xB.
  - Go to EXEC.
- **EXEC**
  - `cnt` decrements each cycle.
  - On the edge where `cnt`==1: capture `alu_result` → `rsp_result` and `alu_result_x` → `rsp_result_x`, set `rsp_valid`, go to RESP.
- **RESP**
  - `rsp_*` hold until `rsp_valid`&`rsp_ready`.
  - On that edge: clear `rsp_valid`, go to IDLE.
  - No bypass: a new command cannot be accepted in the same cycle as the response handshake.
- **Hold rule:** `alu_a`, `alu_b` and `alu_control` change only on an accept edge. They stay stable through EXEC and RESP, which is what makes the ALU's complex ops legal multi-cycle paths.
- **`rsp_err`**
  - Set to 1 when op is 0xC–0xF. The ALU performs an add for these; the result is still returned.
  - Set to 1 when op is 0x9 (divide) and b==0.
  - Otherwise 0. Computed at accept, presented with the response.
- No arithmetic is done in this block; widths pass through unchanged.

## Timing
- **Reset** (rst_n=0 at an edge):
  - State is IDLE and `last`=1.
  - `alu_a`, `alu_b`, `alu_control` = 0.
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_result_x`, `rsp_err` = 0.
  - `busy`=0; both `ready` outputs are 0 during reset.
- **Reset mid-EXEC or mid-RESP:** the in-flight command is dropped with no response. The requester is not retried.
- **Latency:** accept at edge E. `rsp_valid` rises after edge E+1 for simple ops, or after edge E+`LAT_CPLX` for ops 0x8–0xB.
- **Throughput:** with `rsp_ready` held high, the next accept occurs at the earliest at edge E+L+2. That is one op per L+2 cycles.
- `valid` must stay high with stable payload until `ready`. The block never drops an asserted request.

## Test plan
- **Simple add:** req0 a=0x0003, b=0x0005, op=0x0, `rsp_ready`=1. Expect `rsp_valid` 1 cycle after accept, `rsp_result`=0x0008, `rsp_result_x`=0x0000, `rsp_id`=0, `rsp_err`=0.
- **Multiply latency:** req1 a=0x0100, b=0x0100, op=0x8. Expect `rsp_valid` exactly `LAT_CPLX`=4 cycles after accept, `rsp_result`=0x0000, `rsp_result_x`=0x0001, `rsp_id`=1. `alu_*` must be constant across all EXEC cycles.
- **Round-robin:** both requesters continuously valid with op=0x1 for 4 commands. Expect grant order 0,1,0,1, each `ready` pulse lasting a single cycle, and the accept spacing is exactly 3 cycles.
- **Backpressure:** `rsp_ready`=0 for 10 cycles after `rsp_valid`. Expect `rsp_*` held and `busy`=1. Both `ready` outputs stay 0 despite pending valids; accept resumes the cycle after the handshake.
- **Error flags:** div a=0x0010, b=0x0000 gives `rsp_err`=1. Op 0xD with a=2, b=3 gives `rsp_err`=1 and `rsp_result`=0x0005.
- **Reset during EXEC** of a sqrt op: expect `rsp_valid` never asserts and all outputs are 0 after the reset edge. A subsequent req1-only command is granted to 1.
